// File: rtl/gabor_window_gen.sv
// gabor_window_gen
// Streaming 5x5 window generator. Pixels arrive in raster order from a padded
// image of IMG_W x IMG_H. Four line buffers keep the previous four rows, and a
// small column shift register assembles each 5x5 window. The window is then
// presented to conv_unit together with the raster address of its top-left
// pixel.
//
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   pix_in     : raster pixel (PIX_W bits)
//   pix_valid  : pix_in valid
//   pix_sof    : first pixel of a frame (qualified by pix_valid)
//   pix_ready  : pixel accepted when pix_valid && pix_ready
//   win_out    : 25 zero-extended pixels; pixel N at [N*OUT_W-1 -: OUT_W]
//   win_addr   : raster address of the window's top-left pixel
//   win_valid  : window valid
//   win_ready  : consumer accepts when win_valid && win_ready
//   frame_done : one-cycle pulse alongside the last window of a frame
module gabor_window_gen #(
  parameter int IMG_W = 516,
  parameter int IMG_H = 516,
  parameter int PIX_W = 8,
  parameter int OUT_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PIX_W-1:0]     pix_in,
  input  logic                 pix_valid,
  input  logic                 pix_sof,
  output logic                 pix_ready,
  output logic [25*OUT_W-1:0]  win_out,
  output logic [18:0]          win_addr,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic                 frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [RW-1:0]   row_r, row_nxt_s, cur_row_s;
  logic [CW-1:0]   col_r, col_nxt_s, cur_col_s;
  logic            accept_s, take_s, load_s, last_pix_s;
  logic [18:0]     addr_s;

  // lb_mem_r[0] holds row-4 ... lb_mem_r[3] holds row-1 for every column.
  logic [PIX_W-1:0] lb_mem_r [4][IMG_W];
  // Previous four window columns; the fifth column comes straight from
  // the line buffers and pix_in, so it is never stored here.
  logic [PIX_W-1:0] sr_r     [5][4];
  logic [PIX_W-1:0] sr_nxt_s [5][4];
  logic [PIX_W-1:0] col_new_s [5];
  logic [25*OUT_W-1:0] win_nxt_s;

  // The output is a single-entry register, so a pixel may enter only when that register is free or draining.
  assign pix_ready = !win_valid || win_ready;
  assign accept_s  = pix_valid && pix_ready;

  // Frame control: decide whether the accepted pixel is used, its coordinates, and the next counters/state.
  always_comb begin
    state_nxt_s = state_r;
    row_nxt_s   = row_r;
    col_nxt_s   = col_r;
    cur_row_s   = row_r;
    cur_col_s   = col_r;
    take_s      = 1'b0;
    if (accept_s && pix_sof) begin
      // A start-of-frame always restarts the raster at (0,0), even mid-frame.
      take_s    = 1'b1;
      cur_row_s = '0;
      cur_col_s = '0;
    end else if (accept_s && (state_r == ACTIVE)) begin
      take_s = 1'b1;
    end else begin
      take_s = 1'b0;
    end
    last_pix_s = take_s && (cur_row_s == ROW_LAST) && (cur_col_s == COL_LAST);
    load_s     = take_s && (cur_row_s >= RW'(4)) && (cur_col_s >= CW'(4));
    if (take_s) begin
      if (cur_col_s == COL_LAST) begin
        col_nxt_s = '0;
        if (cur_row_s == ROW_LAST) begin
          row_nxt_s   = '0;
          state_nxt_s = IDLE;
        end else begin
          row_nxt_s   = cur_row_s + RW'(1);
          state_nxt_s = ACTIVE;
        end
      end else begin
        col_nxt_s   = cur_col_s + CW'(1);
        row_nxt_s   = cur_row_s;
        state_nxt_s = ACTIVE;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Window datapath: build the new column, the shifted history and the packed window.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      col_new_s[r] = lb_mem_r[r][cur_col_s];
    end
    col_new_s[4] = pix_in;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 3; c++) begin
        sr_nxt_s[r][c] = sr_r[r][c+1];
      end
      sr_nxt_s[r][3] = col_new_s[r];
    end
    win_nxt_s = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        win_nxt_s[(r*5+c)*OUT_W +: OUT_W] = OUT_W'(sr_r[r][c]);
      end
      win_nxt_s[(r*5+4)*OUT_W +: OUT_W] = OUT_W'(col_new_s[r]);
    end
    addr_s = (19'(cur_row_s) - 19'd4) * 19'(IMG_W) + (19'(cur_col_s) - 19'd4);
  end

  // FSM state and raster counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      row_r   <= '0;
      col_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      row_r   <= row_nxt_s;
      col_r   <= col_nxt_s;
    end
  end

  // Line buffers: on each used pixel, the column's history moves up one row and the new pixel enters as row-1.
  always_ff @(posedge clk) begin
    if (take_s) begin
      lb_mem_r[0][cur_col_s] <= lb_mem_r[1][cur_col_s];
      lb_mem_r[1][cur_col_s] <= lb_mem_r[2][cur_col_s];
      lb_mem_r[2][cur_col_s] <= lb_mem_r[3][cur_col_s];
      lb_mem_r[3][cur_col_s] <= pix_in;
    end
  end

  // Column history shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          sr_r[r][c] <= '0;
        end
      end
    end else if (take_s) begin
      sr_r <= sr_nxt_s;
    end
  end

  // Output register: load a completed window, otherwise release it on handoff.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_valid  <= 1'b0;
      win_out    <= '0;
      win_addr   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= load_s && last_pix_s;
      if (load_s) begin
        win_valid <= 1'b1;
        win_out   <= win_nxt_s;
        win_addr  <= addr_s;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gabor_window_gen.sv
// Self-checking bench for gabor_window_gen on an 8x8 padded frame.
// A reference model computes every expected window straight from the stored
// image, and a scoreboard compares each window at handoff.
module tb_gabor_window_gen;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int PW = 8;
  localparam int OW = 10;
  localparam logic [18:0] LAST_ADDR = 19'((H - 5) * W + (W - 5));

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [PW-1:0]     pix_in = '0;
  logic              pix_valid = 1'b0;
  logic              pix_sof = 1'b0;
  logic              pix_ready;
  logic [25*OW-1:0]  win_out;
  logic [18:0]       win_addr;
  logic              win_valid;
  logic              win_ready = 1'b0;
  logic              frame_done;

  gabor_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_ready(pix_ready), .win_out(win_out),
    .win_addr(win_addr), .win_valid(win_valid), .win_ready(win_ready),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [18:0]      addr;
    logic [25*OW-1:0] data;
  } win_t;

  win_t     exp_q[$];
  logic [7:0] img [W*H];
  int total = 0;
  int bad = 0;
  int fd_count = 0;
  int rdy_mode = 0;
  int gap_en = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [OW-1:0] pix_of(input logic [25*OW-1:0] w, input int n);
    return w[n*OW-1 -: OW];
  endfunction

  // Reference model: every window whose bottom-right pixel is among the first npix pixels of the frame.
  task automatic expect_windows(input int npix);
    win_t w;
    int a;
    for (int wr = 0; wr <= H - 5; wr++) begin
      for (int wc = 0; wc <= W - 5; wc++) begin
        a = wr * W + wc;
        if (a + 4 * W + 4 < npix) begin
          w.addr = 19'(a);
          for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
              w.data[(r*5+c)*OW +: OW] = {2'b00, img[a + r*W + c]};
          exp_q.push_back(w);
        end
      end
    end
  endtask

  task automatic fill(input int random_data);
    for (int i = 0; i < W * H; i++)
      img[i] = (random_data != 0) ? 8'($urandom) : 8'(i);
  endtask

  task automatic send_pix(input logic [7:0] p, input logic sof);
    int n;
    logic acc;
    logic done;
    n = 0;
    done = 1'b0;
    if (gap_en != 0) begin
      while ($urandom_range(0, 1) == 1) begin
        pix_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    pix_in = p;
    pix_sof = sof;
    pix_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      acc = pix_ready;
      @(posedge clk); #1;
      n++;
      if (acc) done = 1'b1;
      else if (n > 500) begin
        total++;
        bad++;
        $error("FAIL accept_timeout: observed=no accept expected=accept within 500 cycles");
        done = 1'b1;
      end
    end
    pix_valid = 1'b0;
    pix_sof = 1'b0;
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) send_pix(img[i], i == 0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_drain"}, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Random consumer backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) win_ready = ($urandom_range(0, 1) == 1);
  end

  // Scoreboard and handoff monitor, sampled mid-cycle.
  logic             stall_prev = 1'b0;
  logic [25*OW-1:0] out_prev;
  logic [18:0]      addr_prev;
  win_t             e;
  always @(negedge clk) begin
    if (rst) begin
      if (stall_prev) begin
        chk("hold_valid", win_valid, 1);
        chk("hold_addr", win_addr, addr_prev);
        chk("hold_data", win_out, out_prev);
      end
      if (frame_done) begin
        fd_count++;
        chk("fd_valid", win_valid, 1);
        chk("fd_addr", win_addr, LAST_ADDR);
      end
      if (win_valid && win_ready) begin
        total++;
        assert (exp_q.size() > 0) else begin
          bad++;
          $error("FAIL spurious_window: observed addr=%0d expected no window", win_addr);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("win_addr", win_addr, e.addr);
          chk("win_data", win_out, e.data);
        end
      end
      stall_prev = win_valid && !win_ready;
      out_prev   = win_out;
      addr_prev  = win_addr;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state (win_ready low so pix_ready depends only on win_valid).
    #12;
    chk("rst_valid", win_valid, 0);
    chk("rst_addr", win_addr, 0);
    chk("rst_out", win_out, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_pix_ready", pix_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    win_ready = 1'b1;

    // 1: ramp frame, always ready, spot checks on first and last window.
    fill(0);
    expect_windows(W * H);
    for (int i = 0; i < W * H; i++) begin
      send_pix(img[i], i == 0);
      if (i == 36 || i == 63) begin
        @(negedge clk);
        chk("t1_valid", win_valid, 1);
        if (i == 36) begin
          chk("t1_first_addr", win_addr, 0);
          chk("t1_p1", pix_of(win_out, 1), 0);
          chk("t1_p5", pix_of(win_out, 5), 4);
          chk("t1_p6", pix_of(win_out, 6), 8);
          chk("t1_p25", pix_of(win_out, 25), 36);
        end else begin
          chk("t1_last_addr", win_addr, 27);
          chk("t1_last_p25", pix_of(win_out, 25), 63);
          chk("t1_last_fd", frame_done, 1);
        end
        @(posedge clk); #1;
      end
    end
    drain("t1");
    chk("t1_fd_count", fd_count, 1);

    // 2: stall 10 cycles after the first window.
    expect_windows(W * H);
    for (int i = 0; i < W * H; i++) begin
      send_pix(img[i], i == 0);
      if (i == 36) begin
        win_ready = 1'b0;
        pix_in = img[37];
        pix_valid = 1'b1;
        repeat (10) begin
          @(negedge clk);
          chk("t2_pix_ready", pix_ready, 0);
          chk("t2_addr", win_addr, 0);
          chk("t2_data", win_out, exp_q[0].data);
        end
        @(posedge clk); #1;
        win_ready = 1'b1;
        pix_valid = 1'b0;
      end
    end
    drain("t2");
    chk("t2_fd_count", fd_count, 2);

    // 3: ramp frame with random gaps and random backpressure.
    gap_en = 1;
    rdy_mode = 1;
    expect_windows(W * H);
    send_range(0, W * H - 1);
    drain("t3");
    chk("t3_fd_count", fd_count, 3);

    // 4: two random-data frames back to back.
    for (int f = 0; f < 2; f++) begin
      fill(1);
      expect_windows(W * H);
      send_range(0, W * H - 1);
      drain("t4");
    end
    chk("t4_fd_count", fd_count, 5);
    rdy_mode = 0;
    gap_en = 0;
    win_ready = 1'b1;

    // 5: asynchronous reset at row 5, col 3, then a clean frame.
    fill(0);
    expect_windows(5 * W + 4);
    send_range(0, 5 * W + 3);
    drain("t5_pre");
    @(negedge clk);
    win_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("t5_valid", win_valid, 0);
    chk("t5_fd", frame_done, 0);
    chk("t5_addr", win_addr, 0);
    chk("t5_out", win_out, 0);
    chk("t5_pix_ready", pix_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    win_ready = 1'b1;
    expect_windows(W * H);
    send_range(0, W * H - 1);
    drain("t5");
    chk("t5_fd_count", fd_count, 6);

    // 6: dropped pixels, then a frame cut short by pix_sof at row 6.
    gap_en = 1;
    rdy_mode = 1;
    for (int i = 0; i < 3; i++) send_pix(8'hA5, 1'b0);
    fill(0);
    expect_windows(6 * W + 3);
    send_range(0, 6 * W + 2);
    fill(1);
    expect_windows(W * H);
    send_range(0, W * H - 1);
    drain("t6");
    chk("t6_fd_count", fd_count, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
